// File: rtl/imtx_pkg.sv
// Constants shared with the UART receiver and the imtx FSM state encoding.
package imtx_pkg;
  localparam int unsigned CLK_FREQ   = 100_000_000;
  localparam int unsigned BAUD_RATE  = 9_600;
  localparam int unsigned DIV_BIT    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned FRAME_LEN  = 10;
  localparam int unsigned IMEM_DEPTH = 16384;
  localparam int unsigned ADDR_W     = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } imtx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate strobe: one-clock tick every DIV clocks, restarted by clr.
module uart_baud_tick
  import imtx_pkg::*;
#(
  parameter int unsigned DIV = DIV_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clr;
endmodule

// File: rtl/imtx.sv
// Instruction-memory dump transmitter: reads IMEM bytes and sends them as 8N1 on TxD.
module imtx
  import imtx_pkg::*;
#(
  parameter int unsigned clk_freq  = CLK_FREQ,
  parameter int unsigned baud_rate = BAUD_RATE,
  parameter int unsigned addr_w    = ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] start_addr,
  input  logic [addr_w:0]   byte_count,
  input  logic [7:0]        dout,
  output logic              ena_imtx,
  output logic [addr_w-1:0] addr_imtx,
  output logic              TxD,
  output logic              busy,
  output logic              ImTxComplete
);
  localparam int unsigned div_bit = clk_freq / baud_rate;
  localparam logic [3:0]  LAST_BIT = 4'(FRAME_LEN - 1);

  imtx_state_t          state;
  logic [addr_w:0]      remaining;
  logic [addr_w:0]      remaining_dec;
  logic [FRAME_LEN-1:0] shreg;
  logic [3:0]           bitcnt;
  logic                 baud_clr;
  logic                 baud_tick;

  assign baud_clr      = (state == LOAD);
  assign remaining_dec = remaining - 1'b1;

  uart_baud_tick #(.DIV(div_bit)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (baud_clr),
    .tick  (baud_tick)
  );

  // Frame shift register is pure datapath; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg <= {1'b1, dout, 1'b0};
    end else if (state == SEND && baud_tick) begin
      shreg <= {1'b1, shreg[FRAME_LEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ena_imtx     <= 1'b0;
      addr_imtx    <= '0;
      TxD          <= 1'b1;
      busy         <= 1'b0;
      ImTxComplete <= 1'b0;
      remaining    <= '0;
      bitcnt       <= '0;
    end else begin
      ena_imtx <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_imtx    <= start_addr;
            remaining    <= byte_count;
            ImTxComplete <= 1'b0;
            busy         <= 1'b1;
            if (byte_count == '0) begin
              state <= DONE;
            end else begin
              state    <= FETCH;
              ena_imtx <= 1'b1;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          bitcnt <= '0;
          TxD    <= 1'b0;
          state  <= SEND;
        end
        SEND: begin
          if (baud_tick) begin
            if (bitcnt == LAST_BIT) begin
              TxD   <= 1'b1;
              state <= NEXT;
            end else begin
              // shreg[1] is the bit that becomes shreg[0] after this shift
              TxD    <= shreg[1];
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        NEXT: begin
          addr_imtx <= addr_imtx + 1'b1;
          remaining <= remaining_dec;
          if (remaining_dec == '0) begin
            state <= DONE;
          end else begin
            state    <= FETCH;
            ena_imtx <= 1'b1;
          end
        end
        DONE: begin
          busy         <= 1'b0;
          ImTxComplete <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imtx.sv
// Self-checking bench for imtx with a fast baud (10 clocks per bit) and a BRAM model.
module tb_imtx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [14:0] byte_count = '0;
  logic [7:0]  dout = '0;
  logic        ena_imtx;
  logic [13:0] addr_imtx;
  logic        TxD;
  logic        busy;
  logic        ImTxComplete;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem [16384];

  imtx #(.clk_freq(1_000_000), .baud_rate(100_000), .addr_w(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .byte_count   (byte_count),
    .dout         (dout),
    .ena_imtx     (ena_imtx),
    .addr_imtx    (addr_imtx),
    .TxD          (TxD),
    .busy         (busy),
    .ImTxComplete (ImTxComplete)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ena_imtx) dout <= mem[addr_imtx];

  // Runs one dump and compares every cycle t+1.. against the frame timing model:
  // byte i has its read at t+1+103i and its start bit at t+3+103i, 10 bits x 10 clks,
  // and the dump completes at t+103n+2.
  task automatic run_dump(input logic [13:0] a, input int n, input int pulse_k, input string tag);
    int last, end_k, i0, bi;
    int mis_tx, mis_ena, mis_busy, mis_cmpl;
    int f_tx, f_ena, f_busy, f_cmpl;
    logic etx, eena, ebusy, ecmpl;
    logic [13:0] eaddr, idx;
    logic [7:0] bv;
    mis_tx = 0; mis_ena = 0; mis_busy = 0; mis_cmpl = 0;
    f_tx = 0; f_ena = 0; f_busy = 0; f_cmpl = 0;
    end_k = n * 103 + 2;
    last  = end_k + 2;
    @(negedge clk);
    start_addr = a; byte_count = 15'(n); start = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start = (k == pulse_k);
      if (k == pulse_k) begin
        start_addr = 14'($urandom);
        byte_count = 15'd4;
      end
      etx = 1'b1; eena = 1'b0; eaddr = '0;
      for (int i = 0; i < n; i++) begin
        i0  = 3 + i * 103;
        idx = a + 14'(i);
        if (k == i0 - 2) begin
          eena = 1'b1; eaddr = idx;
        end
        if (k >= i0 && k < i0 + 100) begin
          bi = (k - i0) / 10;
          bv = mem[idx];
          if (bi == 0) etx = 1'b0;
          else if (bi == 9) etx = 1'b1;
          else etx = bv[bi-1];
        end
      end
      ebusy = (k < end_k);
      ecmpl = (k >= end_k);
      if (TxD !== etx) begin mis_tx++; if (f_tx == 0) f_tx = k; end
      if (ena_imtx !== eena || (eena && addr_imtx !== eaddr)) begin
        mis_ena++; if (f_ena == 0) f_ena = k;
      end
      if (!(n == 0 && k == 2) && busy !== ebusy) begin mis_busy++; if (f_busy == 0) f_busy = k; end
      if (ImTxComplete !== ecmpl) begin mis_cmpl++; if (f_cmpl == 0) f_cmpl = k; end
    end
    start = 1'b0;
    checks++;
    if (mis_tx !== 0) begin
      errors++; $display("FAIL %s_txd: %0d bad cycles (first t+%0d), required 0", tag, mis_tx, f_tx);
    end
    checks++;
    if (mis_ena !== 0) begin
      errors++; $display("FAIL %s_bram_read: %0d bad cycles (first t+%0d), required 0", tag, mis_ena, f_ena);
    end
    checks++;
    if (mis_busy !== 0) begin
      errors++; $display("FAIL %s_busy: %0d bad cycles (first t+%0d), required 0", tag, mis_busy, f_busy);
    end
    checks++;
    if (mis_cmpl !== 0) begin
      errors++; $display("FAIL %s_complete: %0d bad cycles (first t+%0d), required 0", tag, mis_cmpl, f_cmpl);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (TxD !== 1'b1 || busy !== 1'b0 || ImTxComplete !== 1'b0 || ena_imtx !== 1'b0 || addr_imtx !== 14'd0) bad++;
    end
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (TxD !== 1'b1 || busy !== 1'b0 || ImTxComplete !== 1'b0 || ena_imtx !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_single();
    mem[5] = 8'hA5;
    run_dump(14'd5, 1, 0, "single");
  endtask

  task automatic test_wrap();
    mem[16383] = 8'h3C;
    mem[0]     = 8'hC3;
    run_dump(14'd16383, 2, 0, "wrap");
  endtask

  task automatic test_zero();
    run_dump(14'($urandom), 0, 0, "zero");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) run_dump(14'($urandom), 1 + int'($urandom_range(0, 2)), 0, "random");
  endtask

  task automatic test_ignore_start();
    run_dump(14'($urandom), 3, 40, "ignore");
  endtask

  task automatic test_reset_mid();
    logic [13:0] a;
    int bad;
    bad = 0;
    a = 14'($urandom);
    mem[a] = 8'h00;
    @(negedge clk);
    start_addr = a; byte_count = 15'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    checks++;
    if (TxD !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: TxD=%b busy=%b, required TxD=0 busy=1", TxD, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (TxD !== 1'b1 || busy !== 1'b0 || ena_imtx !== 1'b0) begin
      errors++; $display("FAIL midreset_async: TxD=%b busy=%b ena=%b, required 1 0 0", TxD, busy, ena_imtx);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (TxD !== 1'b1 || busy !== 1'b0 || ena_imtx !== 1'b0 || ImTxComplete !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL midreset_quiet: %0d bad cycles, required 0", bad);
    end
    run_dump(14'($urandom), 1, 0, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_wrap();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
